// File: rtl/mult_share_pkg.sv
// Shared types and default sizing for the multiplier-sharing controller.
package mult_share_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int DEF_NREQ  = 2;
  localparam int DEF_AW    = 11;
  localparam int DEF_BW    = 11;
  localparam int DEF_SHIFT = 8;

  // A requester index always needs at least one bit, even when NREQ is small.
  function automatic int id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mult_share_ctrl_rr_arbiter.sv
// Combinational round-robin grant: first set req bit at or after ptr, wrapping.
// Zero latency; no state, so fairness depends on the caller advancing ptr.
module rr_arbiter
  import mult_share_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int IW   = id_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   gnt_idx,
  output logic            gnt_vld
);

  logic [IW-1:0] k;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    k       = '0;
    for (int i = 0; i < NREQ; i++) begin
      k = IW'((32'(ptr) + i) % NREQ);
      if (!gnt_vld && req[k]) begin
        gnt_vld = 1'b1;
        gnt[k]  = 1'b1;
        gnt_idx = k;
      end
    end
  end

endmodule

// File: rtl/mult_share_ctrl.sv
// One scaled multiplier shared by NREQ requesters: IDLE -> MUL -> RESP, result held until res_ready.
// MULT_SHARE_ROUND_EN selects round-half-up instead of truncation on the >>SHIFT.
module mult_share_ctrl
  import mult_share_pkg::*;
#(
  parameter int  NREQ  = DEF_NREQ,
  parameter int  AW    = DEF_AW,
  parameter int  BW    = DEF_BW,
  parameter int  SHIFT = DEF_SHIFT,
  localparam int RW    = AW + BW - SHIFT,
  localparam int IW    = id_w(NREQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*AW-1:0]   op_a,
  input  logic [NREQ*BW-1:0]   op_b,
  output logic [NREQ-1:0]      ack,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [RW-1:0]    res_data,
  output logic [IW-1:0]    res_id,
  output logic             busy
);

  state_t          state_q, state_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic [AW-1:0]   a_q, a_d;
  logic [BW-1:0]   b_q, b_d;
  logic [IW-1:0]   id_q, id_d;
  logic [RW-1:0]   data_q, data_d;

  logic [NREQ-1:0] gnt;
  logic [IW-1:0]   gnt_idx;
  logic            gnt_vld;

  logic [AW+BW-1:0] prod;
  logic [RW-1:0]    scaled;

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
    .req     (req),
    .ptr     (rr_ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  assign prod = (AW+BW)'(a_q) * (AW+BW)'(b_q);

`ifdef MULT_SHARE_ROUND_EN
  // One extra bit so the rounding addend can never wrap the sum.
  logic [AW+BW:0] rounded;
  assign rounded = {1'b0, prod} + ((AW+BW+1)'(1) << (SHIFT-1));
  assign scaled  = RW'(rounded >> SHIFT);
`else
  assign scaled  = RW'(prod >> SHIFT);
`endif

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    ack_d    = '0;
    a_d      = a_q;
    b_d      = b_q;
    id_d     = id_q;
    data_d   = data_q;
    case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          a_d      = op_a[int'(gnt_idx)*AW +: AW];
          b_d      = op_b[int'(gnt_idx)*BW +: BW];
          id_d     = gnt_idx;
          ack_d    = gnt;
          rr_ptr_d = (gnt_idx == IW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
          state_d  = MUL;
        end
      end
      MUL: begin
        data_d  = scaled;
        state_d = RESP;
      end
      RESP: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      ack_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      id_q     <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      ack_q    <= ack_d;
      a_q      <= a_d;
      b_q      <= b_d;
      id_q     <= id_d;
      data_q   <= data_d;
    end
  end

  assign ack       = ack_q;
  assign res_valid = (state_q == RESP);
  assign res_data  = data_q;
  assign res_id    = id_q;
  assign busy      = (state_q != IDLE);

endmodule
